// File: rtl/ctrl_decode_pipe.sv
// MIPS main control decoder with built-in ID/EX control register, load-use stall and branch flush.
// Optional JAL/JALR link decoding is enabled by defining LINK_EN.
module ctrl_decode_pipe #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int HAZARD_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [5:0]            op_code,
    input  logic [5:0]            funct,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  branch_taken,
    output logic                  ex_reg_dst,
    output logic                  ex_alu_src,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_link,
    output logic [1:0]            ex_alu_op,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  ex_valid,
    output logic                  ex_illegal,
    output logic                  stall_out,
    output logic                  flush_out
);

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       link;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [1:0] FLUSH_M1 = 2'(FLUSH_CYCLES - 1);

    state_t                state;
    logic [1:0]            cnt;
    ctrl_t                 dec, ex_q, ex_d;
    logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
    logic                  ex_valid_q, ex_valid_d;
    logic                  hazard;

    always_comb begin
        dec = '0;
        case (op_code)
            6'b000000: begin
                if (funct == 6'b000000) begin
                    dec = '0;
                end else if (funct == 6'b001000) begin
                    dec.branch = 1'b1;
                end else if (funct == 6'b001001) begin
                    dec.branch = 1'b1;
`ifdef LINK_EN
                    dec.reg_write = 1'b1;
                    dec.reg_dst   = 1'b1;
                    dec.link      = 1'b1;
`endif
                end else begin
                    dec.reg_dst   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 2'b10;
                end
            end
            6'b100000, 6'b100001, 6'b100011: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b11;
            end
            6'b000100, 6'b000101, 6'b000010: dec.branch = 1'b1;
`ifdef LINK_EN
            6'b000011: begin
                dec.branch    = 1'b1;
                dec.reg_write = 1'b1;
                dec.link      = 1'b1;
            end
`endif
            default: dec.illegal = 1'b1;
        endcase
    end

    // Only an in-flight load can create a use hazard; $zero never does.
    assign hazard = (HAZARD_EN != 0) && instr_valid && ex_valid_q && ex_q.mem_read &&
                    (ex_rt_q != '0) && ((ex_rt_q == rs) || (ex_rt_q == rt));

    assign flush_out = rst_n && (branch_taken || (state == FLUSH));
    assign stall_out = rst_n && !flush_out && hazard;

    always_comb begin
        ex_d       = '0;
        ex_rt_d    = '0;
        ex_valid_d = 1'b0;
        if (!flush_out && !stall_out && instr_valid) begin
            ex_d       = dec;
            ex_rt_d    = rt;
            ex_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            cnt        <= '0;
            ex_q       <= '0;
            ex_rt_q    <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            ex_rt_q    <= ex_rt_d;
            ex_valid_q <= ex_valid_d;
            // A new taken branch always restarts the bubble window.
            if (branch_taken) begin
                cnt   <= FLUSH_M1;
                state <= (FLUSH_M1 != 2'd0) ? FLUSH : RUN;
            end else if (state == FLUSH) begin
                cnt   <= cnt - 2'd1;
                state <= (cnt == 2'd1) ? RUN : FLUSH;
            end
        end
    end

    assign ex_reg_dst    = ex_q.reg_dst;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_branch     = ex_q.branch;
    assign ex_link       = ex_q.link;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_illegal    = ex_q.illegal;
    assign ex_rt         = ex_rt_q;
    assign ex_valid      = ex_valid_q;

endmodule
